// File: rtl/cva6_rvfi_trace_serializer_pkg.sv
// Shared types for the RVFI trace serializer.
// Holds a minimal core config and a default retirement record layout.
package cva6_rvfi_trace_serializer_pkg;

    // Core configuration slice: only the commit port count is consumed here.
    typedef struct packed {
        logic [31:0] NrCommitPorts;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 32'd2};

    // Default retirement record; any packed record with a 1-bit valid works.
    typedef struct packed {
        logic        valid;
        logic [31:0] insn;
        logic [63:0] pc_rdata;
    } rvfi_instr_default_t;

    localparam int unsigned ORDER_W = 64;

endpackage

// File: rtl/cva6_rvfi_trace_fifo.sv
// Multi-push, single-pop circular buffer.
// Enabled push slots are packed in slot order after the tail.
module cva6_rvfi_trace_fifo #(
    parameter type         entry_t = logic,
    parameter int unsigned NPUSH   = 2,
    parameter int unsigned DEPTH   = 8,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned CW     = AW + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NPUSH-1:0]        push_i,
    input  entry_t [NPUSH-1:0]      data_i,
    input  logic                    pop_i,
    output entry_t                  data_o,
    output logic [CW-1:0]           free_o,
    output logic [CW-1:0]           occupancy_o
);

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] rptr_q;
    logic [AW-1:0] wptr_q;
    logic [CW-1:0] occ_q;
    logic          pop;
    logic [CW-1:0] npush;
    logic [AW-1:0] slot_idx [NPUSH];

    assign pop         = pop_i && (occ_q != '0);
    assign data_o      = mem_q[rptr_q];
    assign occupancy_o = occ_q;
    // A pop in this cycle frees its slot for a same-cycle push.
    assign free_o      = CW'(DEPTH) - occ_q + CW'(pop);

    // Write index of each enabled slot: tail plus enabled slots before it.
    always_comb begin
        npush = '0;
        for (int unsigned k = 0; k < NPUSH; k++) begin
            slot_idx[k] = wptr_q + AW'(npush);
            if (push_i[k]) begin
                npush = npush + CW'(1);
            end
        end
    end

    // Storage, zeroed on reset so the head reads as all-zero when empty.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NPUSH; k++) begin
                if (push_i[k]) begin
                    mem_q[slot_idx[k]] <= data_i[k];
                end
            end
        end
    end

    // Pointers and fill level; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q <= '0;
            wptr_q <= '0;
            occ_q  <= '0;
        end else begin
            rptr_q <= rptr_q + AW'(pop);
            wptr_q <= wptr_q + AW'(npush);
            occ_q  <= occ_q + npush - CW'(pop);
        end
    end

endmodule

// File: rtl/cva6_rvfi_trace_serializer.sv
// Tags RVFI retirements with a 64-bit order and streams them out
// one per cycle; records that do not fit are dropped and counted.
module cva6_rvfi_trace_serializer
    import cva6_rvfi_trace_serializer_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg      = cva6_cfg_empty,
    parameter type         rvfi_instr_t = rvfi_instr_default_t,
    parameter int unsigned DEPTH        = 8,
    localparam int unsigned NP          = CVA6Cfg.NrCommitPorts,
    localparam int unsigned CW          = $clog2(DEPTH) + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  rvfi_instr_t [NP-1:0]   rvfi_instr_i,
    output logic                   trace_valid_o,
    input  logic                   trace_ready_i,
    output rvfi_instr_t            trace_instr_o,
    output logic [ORDER_W-1:0]     trace_order_o,
    output logic [CW-1:0]          occupancy_o,
    output logic                   overflow_o,
    output logic [31:0]            drop_cnt_o,
    input  logic                   clear_i
);

    typedef struct packed {
        rvfi_instr_t        instr;
        logic [ORDER_W-1:0] order;
    } entry_t;

    logic [ORDER_W-1:0] order_q;
    logic [31:0]        drop_cnt_q;
    logic               overflow_q;

    logic [NP-1:0]      present;
    logic [CW-1:0]      nvalid;
    logic [CW-1:0]      free;
    logic [CW-1:0]      occupancy;
    logic [CW-1:0]      accepted;
    logic [CW-1:0]      dropped;
    logic [NP-1:0]      slot_en;
    entry_t [NP-1:0]    slot_data;
    entry_t             head;
    logic               pop;

    logic [31:0]        cnt_base;
    logic [32:0]        cnt_sum;
    logic [31:0]        drop_cnt_d;
    logic               overflow_d;

    // A port counts only through its valid bit; other fields are ignored.
    always_comb begin
        present = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            present[i] = rvfi_instr_i[i].valid;
        end
    end

    // Compact present records by rank, tag orders, enable what fits.
    always_comb begin
        int unsigned rank;
        rank      = 0;
        slot_en   = '0;
        slot_data = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            if (present[i]) begin
                slot_data[rank].instr = rvfi_instr_i[i];
                slot_data[rank].order = order_q + ORDER_W'(rank);
                slot_en[rank]         = rank < 32'(free);
                rank                  = rank + 1;
            end
        end
        nvalid = CW'(rank);
    end

    assign accepted = (nvalid < free) ? nvalid : free;
    assign dropped  = nvalid - accepted;

    // Clear takes effect before this cycle's drops are added.
    always_comb begin
        cnt_base   = clear_i ? 32'd0 : drop_cnt_q;
        cnt_sum    = {1'b0, cnt_base} + 33'(dropped);
        drop_cnt_d = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
        overflow_d = (clear_i ? 1'b0 : overflow_q) | (dropped != '0);
    end

    // Order advances for every present record, dropped ones included.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            order_q <= '0;
        end else begin
            order_q <= order_q + ORDER_W'(nvalid);
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    cva6_rvfi_trace_fifo #(
        .entry_t (entry_t),
        .NPUSH   (NP),
        .DEPTH   (DEPTH)
    ) i_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (slot_en),
        .data_i      (slot_data),
        .pop_i       (pop),
        .data_o      (head),
        .free_o      (free),
        .occupancy_o (occupancy)
    );

    assign trace_valid_o = occupancy != '0;
    assign pop           = trace_valid_o && trace_ready_i;
    assign trace_instr_o = head.instr;
    assign trace_order_o = head.order;
    assign occupancy_o   = occupancy;
    assign overflow_o    = overflow_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_cva6_rvfi_trace_serializer.sv
// Randomized bench for the RVFI trace serializer.
// A queue model of the trace stream predicts every output.
module tb_cva6_rvfi_trace_serializer;
    import cva6_rvfi_trace_serializer_pkg::*;

    localparam int NP    = 2;
    localparam int DEPTH = 8;

    typedef struct {
        rvfi_instr_default_t instr;
        logic [63:0]         order;
    } ent_t;

    logic                          clk   = 1'b0;
    logic                          rst_n = 1'b0;
    logic                          ready = 1'b0;
    logic                          clear = 1'b0;
    rvfi_instr_default_t [NP-1:0]  rvfi  = '0;
    logic                          trace_valid;
    rvfi_instr_default_t           trace_instr;
    logic [63:0]                   trace_order;
    logic [3:0]                    occupancy;
    logic                          overflow;
    logic [31:0]                   drop_cnt;

    int checks   = 0;
    int failures = 0;

    ent_t              q[$];
    logic [63:0]       m_order = '0;
    longint unsigned   m_drop  = 0;
    bit                m_ovf   = 0;

    always #5 clk = ~clk;

    cva6_rvfi_trace_serializer #(
        .CVA6Cfg      (cva6_cfg_t'{NrCommitPorts: 32'd2}),
        .rvfi_instr_t (rvfi_instr_default_t),
        .DEPTH        (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .rvfi_instr_i  (rvfi),
        .trace_valid_o (trace_valid),
        .trace_ready_i (ready),
        .trace_instr_o (trace_instr),
        .trace_order_o (trace_order),
        .occupancy_o   (occupancy),
        .overflow_o    (overflow),
        .drop_cnt_o    (drop_cnt),
        .clear_i       (clear)
    );

    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic rvfi_instr_default_t mk(bit v);
        rvfi_instr_default_t r;
        r.valid    = v;
        r.insn     = $urandom;
        r.pc_rdata = {$urandom, $urandom};
        return r;
    endfunction

    task automatic compare_all();
        check("valid", 128'(trace_valid), 128'(q.size() != 0));
        check("occupancy", 128'(occupancy), 128'(q.size()));
        check("overflow", 128'(overflow), 128'(m_ovf));
        check("drop_cnt", 128'(drop_cnt), 128'(m_drop));
        if (q.size() != 0) begin
            check("instr", 128'(trace_instr), 128'(q[0].instr));
            check("order", 128'(trace_order), 128'(q[0].order));
        end
    endtask

    // Stream-level model: pop head, append present records while room.
    task automatic model_step();
        int   dropped;
        int   rank;
        ent_t e;
        dropped = 0;
        rank    = 0;
        if (q.size() != 0 && ready) void'(q.pop_front());
        for (int i = 0; i < NP; i++) begin
            if (rvfi[i].valid) begin
                e.instr = rvfi[i];
                e.order = m_order + 64'(rank);
                rank++;
                if (q.size() < DEPTH) q.push_back(e);
                else dropped++;
            end
        end
        m_order = m_order + 64'(rank);
        if (clear) begin
            m_drop = 0;
            m_ovf  = 0;
        end
        if (dropped != 0) begin
            m_ovf  = 1;
            m_drop = m_drop + longint'(dropped);
            if (m_drop > 64'hFFFF_FFFF) m_drop = 64'hFFFF_FFFF;
        end
    endtask

    task automatic step(bit v0, bit v1, bit rdy, bit clr);
        compare_all();
        rvfi[0] = mk(v0);
        rvfi[1] = mk(v1);
        ready   = rdy;
        clear   = clr;
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_mid();
        rst_n = 1'b0;
        #1;
        check("rst_valid", 128'(trace_valid), 128'(0));
        check("rst_occ", 128'(occupancy), 128'(0));
        q.delete();
        m_order = '0;
        m_drop  = 0;
        m_ovf   = 0;
        rvfi    = '0;
        ready   = 1'b0;
        clear   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_instr", 128'(trace_instr), 128'(0));
        check("rst_order", 128'(trace_order), 128'(0));
        compare_all();
        rst_n = 1'b1;

        // single port, back-to-back, drained every cycle
        repeat (3) step(1, 0, 1, 0);
        repeat (3) step(0, 0, 1, 0);

        // two ports in one cycle
        step(1, 1, 1, 0);
        check("occ_pair", 128'(occupancy), 128'(2));
        repeat (3) step(0, 0, 1, 0);

        // only port 1 valid
        step(0, 1, 1, 0);
        repeat (2) step(0, 0, 1, 0);

        // overfill with the sink stalled, then drain
        reset_mid();
        repeat (5) step(1, 1, 0, 0);
        check("full_occ", 128'(occupancy), 128'(8));
        check("full_ovf", 128'(overflow), 128'(1));
        check("full_drop", 128'(drop_cnt), 128'(2));
        repeat (8) step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        check("order10", 128'(trace_order), 128'(10));

        // push while full with a same-cycle pop, clear vs drop ordering
        step(1, 1, 0, 1);
        step(1, 1, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        check("pp_occ", 128'(occupancy), 128'(8));
        check("pp_drop", 128'(drop_cnt), 128'(0));
        step(1, 1, 0, 0);
        step(1, 0, 0, 1);
        check("clr_ovf", 128'(overflow), 128'(1));
        check("clr_drop", 128'(drop_cnt), 128'(1));
        step(0, 0, 0, 1);
        check("clr_only", 128'({overflow, drop_cnt}), 128'(0));

        // stalled head stays stable, then reset mid-stream
        repeat (4) step(0, 0, 0, 0);
        reset_mid();
        step(1, 0, 1, 0);
        check("post_rst_valid", 128'(trace_valid), 128'(1));
        check("post_rst_order", 128'(trace_order), 128'(0));

        // random traffic with alternating sink pressure
        for (int n = 0; n < 400; n++) begin
            bit rdy;
            if (((n / 50) % 2) == 0) rdy = ($urandom_range(0, 3) != 0);
            else rdy = ($urandom_range(0, 3) == 0);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 rdy, ($urandom_range(0, 15) == 0));
        end
        repeat (10) step(0, 0, 1, 0);
        compare_all();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
